alarm_ctrl_fsm: RTL and testbench

Sequencing controller for the digital clock's display/alarm datapath. It decodes the keypad and the ALARM/TIME buttons into single-cycle control strobes:
- digit shift into the key register;
- load of the alarm register;
- load of the current-time counter.

It also drives the display select lines, including `show_alarm` into the display multiplexer. All outputs are Moore-decoded from a registered state, so the downstream datapath sees glitch-free, state-aligned controls.

---
 rtl/alarm_ctrl_fsm.sv | 126 ++++++++++++
 tb/tb_alarm_ctrl_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl_fsm.sv
// alarm_ctrl_fsm: keypad / ALARM / TIME button sequencer for the clock's
// display and alarm datapath. Produces single-cycle load/shift strobes and
// display selects, all flopped so they change only on a clock edge.
//
// Optional feature macro: ALARM_CTRL_TIMEOUT_EN
//   defined   -> inactivity timeout (sec_cnt) abandons digit entry
//   undefined -> entry states wait indefinitely, one_second unused
//
// state              | meaning
// -------------------+-----------------------------------------------
// S_SHOW_TIME        | idle, display current time
// S_KEY_STORED       | digit just pressed, shift it in (1 cycle)
// S_KEY_WAITED       | waiting for the pressed key to be released
// S_KEY_ENTRY        | key released, waiting for next digit or button
// S_SHOW_ALARM       | ALARM held, display alarm time
// S_SET_ALARM_TIME   | load key register into alarm register (1 cycle)
// S_SET_CURRENT_TIME | load key register into time counter (1 cycle)
module alarm_ctrl_fsm #(
  parameter logic [3:0] NOKEY       = 4'hA,
  parameter int         TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_alarm
);

  typedef enum logic [2:0] {
    S_SHOW_TIME        = 3'd0,
    S_KEY_STORED       = 3'd1,
    S_KEY_WAITED       = 3'd2,
    S_KEY_ENTRY        = 3'd3,
    S_SHOW_ALARM       = 3'd4,
    S_SET_ALARM_TIME   = 3'd5,
    S_SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_timeout;
  logic   w_key_pressed;

  assign w_key_pressed = (key != NOKEY);

`ifdef ALARM_CTRL_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_SEC - 1);

  logic [3:0] r_sec_cnt;
  logic       w_counting;

  assign w_counting = (r_state == S_KEY_WAITED) || (r_state == S_KEY_ENTRY);
  assign w_timeout  = w_counting && one_second && (r_sec_cnt == TO_LAST);

  // Inactivity seconds counter; only runs while waiting for keypad input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sec_cnt <= 4'd0;
    end else if (!w_counting || w_timeout) begin
      r_sec_cnt <= 4'd0;
    end else if (one_second) begin
      r_sec_cnt <= r_sec_cnt + 4'd1;
    end
  end
`else
  logic w_unused_one_second;

  assign w_unused_one_second = one_second;
  assign w_timeout           = 1'b0;
`endif

  // Next-state decode; alarm load outranks time load in KEY_ENTRY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SHOW_TIME: begin
        if (alarm_button)       w_state_nxt = S_SHOW_ALARM;
        else if (w_key_pressed) w_state_nxt = S_KEY_STORED;
      end
      S_KEY_STORED: w_state_nxt = S_KEY_WAITED;
      S_KEY_WAITED: begin
        if (w_timeout)          w_state_nxt = S_SHOW_TIME;
        else if (!w_key_pressed) w_state_nxt = S_KEY_ENTRY;
      end
      S_KEY_ENTRY: begin
        if (alarm_button)       w_state_nxt = S_SET_ALARM_TIME;
        else if (time_button)   w_state_nxt = S_SET_CURRENT_TIME;
        else if (w_key_pressed) w_state_nxt = S_KEY_STORED;
        else if (w_timeout)     w_state_nxt = S_SHOW_TIME;
      end
      S_SHOW_ALARM: begin
        if (!alarm_button)      w_state_nxt = S_SHOW_TIME;
      end
      S_SET_ALARM_TIME:   w_state_nxt = S_SHOW_TIME;
      S_SET_CURRENT_TIME: w_state_nxt = S_SHOW_TIME;
      default:            w_state_nxt = S_SHOW_TIME;
    endcase
  end

  // State register with outputs flopped from the next state, so each
  // output is a pure function of the registered state it accompanies.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_SHOW_TIME;
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      show_new_time <= 1'b0;
      show_alarm    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      shift         <= (w_state_nxt == S_KEY_STORED);
      load_new_a    <= (w_state_nxt == S_SET_ALARM_TIME);
      load_new_c    <= (w_state_nxt == S_SET_CURRENT_TIME);
      show_new_time <= (w_state_nxt == S_KEY_WAITED) || (w_state_nxt == S_KEY_ENTRY);
      show_alarm    <= (w_state_nxt == S_SHOW_ALARM);
    end
  end

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Self-checking bench for alarm_ctrl_fsm: table-driven directed vectors,
// hand-written corner sequences, then random stimulus against a model.
module tb_alarm_ctrl_fsm;

  localparam logic [3:0] NOKEY   = 4'hA;
  localparam int         TIMEOUT = 10;

`ifdef ALARM_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // expected-output bundle order: {shift, load_new_a, load_new_c, show_new_time, show_alarm}
  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_SH   = 5'b10000;
  localparam logic [4:0] E_LA   = 5'b01000;
  localparam logic [4:0] E_LC   = 5'b00100;
  localparam logic [4:0] E_SN   = 5'b00010;
  localparam logic [4:0] E_SA   = 5'b00001;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = NOKEY;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       shift, load_new_a, load_new_c, show_new_time, show_alarm;
  logic [4:0] dut_o;

  int n_checks = 0;
  int n_fail   = 0;

  assign dut_o = {shift, load_new_a, load_new_c, show_new_time, show_alarm};

  alarm_ctrl_fsm #(.NOKEY(NOKEY), .TIMEOUT_SEC(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .one_second(one_second), .key(key),
    .alarm_button(alarm_button), .time_button(time_button),
    .shift(shift), .load_new_a(load_new_a), .load_new_c(load_new_c),
    .show_new_time(show_new_time), .show_alarm(show_alarm)
  );

  always #5 clock = ~clock;

  // Behavioural model: "what the user is doing" plus seconds idle.
  localparam int M_IDLE = 0, M_JUST_PRESSED = 1, M_HOLDING = 2, M_TYPING = 3,
                 M_VIEW_ALARM = 4, M_COMMIT_ALARM = 5, M_COMMIT_TIME = 6;
  int m_mode = M_IDLE;
  int m_idle_secs = 0;

  function automatic logic [4:0] model_out();
    case (m_mode)
      M_JUST_PRESSED: return E_SH;
      M_HOLDING, M_TYPING: return E_SN;
      M_VIEW_ALARM:   return E_SA;
      M_COMMIT_ALARM: return E_LA;
      M_COMMIT_TIME:  return E_LC;
      default:        return E_NONE;
    endcase
  endfunction

  task automatic model_step();
    bit waiting, expired, pressed;
    waiting = (m_mode == M_HOLDING) || (m_mode == M_TYPING);
    pressed = (key != NOKEY);
    expired = TO_EN && waiting && one_second && (m_idle_secs + 1 >= TIMEOUT);
    if (!waiting || expired) m_idle_secs = 0;
    else if (one_second)     m_idle_secs = m_idle_secs + 1;
    case (m_mode)
      M_IDLE:         m_mode = alarm_button ? M_VIEW_ALARM : (pressed ? M_JUST_PRESSED : M_IDLE);
      M_JUST_PRESSED: m_mode = M_HOLDING;
      M_HOLDING:      m_mode = expired ? M_IDLE : (!pressed ? M_TYPING : M_HOLDING);
      M_TYPING: begin
        if (alarm_button)     m_mode = M_COMMIT_ALARM;
        else if (time_button) m_mode = M_COMMIT_TIME;
        else if (pressed)     m_mode = M_JUST_PRESSED;
        else if (expired)     m_mode = M_IDLE;
      end
      M_VIEW_ALARM:   m_mode = alarm_button ? M_VIEW_ALARM : M_IDLE;
      default:        m_mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: outputs got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, edge, model update, settle to next negedge.
  task automatic cyc(input logic [3:0] k, input logic ab, input logic tb, input logic os);
    key = k; alarm_button = ab; time_button = tb; one_second = os;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic enter_digit(input logic [3:0] d);
    cyc(d, 0, 0, 0);
    check("digit_shift", dut_o, E_SH);
    cyc(NOKEY, 0, 0, 0);
    cyc(NOKEY, 0, 0, 0);
    check("digit_entry", dut_o, E_SN);
  endtask

  typedef struct {
    logic [3:0] k;
    logic       ab;
    logic       tb;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] k, input logic ab, input logic tb, input logic [4:0] exp);
    vec_t v;
    v.k = k; v.ab = ab; v.tb = tb; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    // key 3 held 5 cycles then released
    add(4'h3, 0, 0, E_SH);
    add(4'h3, 0, 0, E_SN);
    add(4'h3, 0, 0, E_SN);
    add(4'h3, 0, 0, E_SN);
    add(4'h3, 0, 0, E_SN);
    add(NOKEY, 0, 0, E_SN);
    // digits 1,2,3,0 then a one-cycle alarm pulse
    for (int d = 0; d < 4; d++) begin
      add((d == 3) ? 4'h0 : 4'(d + 1), 0, 0, E_SH);
      add(NOKEY, 0, 0, E_SN);
      add(NOKEY, 0, 0, E_SN);
    end
    add(NOKEY, 1, 0, E_LA);
    add(NOKEY, 0, 0, E_NONE);
    add(NOKEY, 0, 1, E_NONE);   // time_button ignored in SHOW_TIME
    add(NOKEY, 0, 0, E_NONE);

    repeat (3) @(negedge clock);
    check("reset_state", dut_o, E_NONE);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].k, vecs[i].ab, vecs[i].tb, 1'b0);
      check($sformatf("vec%0d", i), dut_o, vecs[i].exp);
    end

    // ALARM held 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc(NOKEY, 1, 0, 0);
      check($sformatf("alarm_hold%0d", i), dut_o, E_SA);
    end
    cyc(NOKEY, 0, 0, 0);
    check("alarm_release", dut_o, E_NONE);

    // inactivity timeout after TIMEOUT one_second pulses
    enter_digit(4'h5);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cyc(NOKEY, 0, 0, 1);
      if (i == TIMEOUT - 1) check("timeout_pre", dut_o, E_SN);
      if (i == TIMEOUT) check("timeout_end", dut_o, TO_EN ? E_NONE : E_SN);
      cyc(NOKEY, 0, 0, 0);
    end
    check("timeout_after", dut_o, TO_EN ? E_NONE : E_SN);

    // both buttons in KEY_ENTRY: alarm load wins
    enter_digit(4'h7);
    cyc(NOKEY, 1, 1, 0);
    check("both_buttons", dut_o, E_LA);
    cyc(NOKEY, 0, 0, 0);
    check("both_after", dut_o, E_NONE);

    // reset during SET_CURRENT_TIME truncates load_new_c
    enter_digit(4'h9);
    cyc(NOKEY, 0, 1, 0);
    check("load_c", dut_o, E_LC);
    #1 reset_n = 1'b0;
    #1;
    check("reset_truncate", dut_o, E_NONE);
    m_mode = M_IDLE; m_idle_secs = 0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc(NOKEY, 0, 0, 0);
    check("post_reset", dut_o, E_NONE);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 9)) : NOKEY;
      cyc(k, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      check("random", dut_o, model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
